// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter for the shared 8-bit data / 16-bit address memory bus, with
// round-robin or fixed priority and a watchdog that aborts a stalled access.
module mem_bus_arbiter #(
    parameter int unsigned RR      = 1,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic [15:0] m0_addr,
    input  logic [7:0]  m0_wdata,
    input  logic        m0_read,
    input  logic        m0_write,
    output logic [7:0]  m0_rdata,
    output logic        m0_ready,
    output logic        m0_err,

    input  logic [15:0] m1_addr,
    input  logic [7:0]  m1_wdata,
    input  logic        m1_read,
    input  logic        m1_write,
    output logic [7:0]  m1_rdata,
    output logic        m1_ready,
    output logic        m1_err,

    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ready,

    output logic [1:0]  grant,
    output logic        busy,
    output logic        timeout_err
);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    localparam logic [7:0] CntLast    = 8'(TIMEOUT - 1);
    localparam bit         RoundRobin = (RR != 0);

    state_e      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [1:0]  grant_q, grant_d;
    logic        busy_q, busy_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [7:0]  mem_wdata_q, mem_wdata_d;
    logic        mem_read_q, mem_read_d;
    logic        mem_write_q, mem_write_d;
    logic [7:0]  m0_rdata_q, m0_rdata_d;
    logic [7:0]  m1_rdata_q, m1_rdata_d;
    logic        m0_ready_q, m0_ready_d;
    logic        m1_ready_q, m1_ready_d;
    logic        m0_err_q, m0_err_d;
    logic        m1_err_q, m1_err_d;
    logic        timeout_err_q, timeout_err_d;

    logic        req0, req1, pick_m1, pick_wr;

    // last_grant_q = 1 means master 1 was served last, so master 0 wins the next tie.
    always_comb begin
        req0 = m0_read | m0_write;
        req1 = m1_read | m1_write;
        if (req0 && req1) begin
            pick_m1 = RoundRobin ? ~last_grant_q : 1'b0;
        end else begin
            pick_m1 = req1;
        end
        pick_wr = pick_m1 ? m1_write : m0_write;
    end

    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        cnt_d         = cnt_q;
        grant_d       = grant_q;
        busy_d        = busy_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        mem_read_d    = mem_read_q;
        mem_write_d   = mem_write_q;
        m0_rdata_d    = m0_rdata_q;
        m1_rdata_d    = m1_rdata_q;
        m0_ready_d    = 1'b0;
        m1_ready_d    = 1'b0;
        m0_err_d      = 1'b0;
        m1_err_d      = 1'b0;
        timeout_err_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req0 || req1) begin
                    grant_d      = pick_m1 ? 2'b10 : 2'b01;
                    last_grant_d = pick_m1;
                    mem_addr_d   = pick_m1 ? m1_addr : m0_addr;
                    mem_wdata_d  = pick_m1 ? m1_wdata : m0_wdata;
                    mem_write_d  = pick_wr;
                    mem_read_d   = ~pick_wr;
                    cnt_d        = 8'd0;
                    busy_d       = 1'b1;
                    state_d      = StAccess;
                end
            end
            StAccess: begin
                if (mem_ready) begin
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    if (grant_q[1]) begin
                        m1_rdata_d = mem_rdata;
                        m1_ready_d = 1'b1;
                    end else begin
                        m0_rdata_d = mem_rdata;
                        m0_ready_d = 1'b1;
                    end
                    state_d = StResp;
                end else if (cnt_q == CntLast) begin
                    mem_read_d    = 1'b0;
                    mem_write_d   = 1'b0;
                    timeout_err_d = 1'b1;
                    if (grant_q[1]) begin
                        m1_rdata_d = 8'hFF;
                        m1_ready_d = 1'b1;
                        m1_err_d   = 1'b1;
                    end else begin
                        m0_rdata_d = 8'hFF;
                        m0_ready_d = 1'b1;
                        m0_err_d   = 1'b1;
                    end
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StResp: begin
                grant_d = 2'b00;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: begin
                grant_d = 2'b00;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            last_grant_q  <= 1'b1;
            cnt_q         <= 8'd0;
            grant_q       <= 2'b00;
            busy_q        <= 1'b0;
            mem_addr_q    <= 16'h0000;
            mem_wdata_q   <= 8'h00;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            m0_rdata_q    <= 8'h00;
            m1_rdata_q    <= 8'h00;
            m0_ready_q    <= 1'b0;
            m1_ready_q    <= 1'b0;
            m0_err_q      <= 1'b0;
            m1_err_q      <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            cnt_q         <= cnt_d;
            grant_q       <= grant_d;
            busy_q        <= busy_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
            m0_rdata_q    <= m0_rdata_d;
            m1_rdata_q    <= m1_rdata_d;
            m0_ready_q    <= m0_ready_d;
            m1_ready_q    <= m1_ready_d;
            m0_err_q      <= m0_err_d;
            m1_err_q      <= m1_err_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign m0_rdata    = m0_rdata_q;
    assign m0_ready    = m0_ready_q;
    assign m0_err      = m0_err_q;
    assign m1_rdata    = m1_rdata_q;
    assign m1_ready    = m1_ready_q;
    assign m1_err      = m1_err_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;
    assign grant       = grant_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized bench for mem_bus_arbiter: a transaction-level timeline model predicts every
// output each cycle; a second fixed-priority instance checks master 0 always wins.
module tb_mem_bus_arbiter;

    localparam int unsigned To = 8;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  wdata;
        int          gap;
        int          lat;
    } op_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Round-robin instance
    logic [15:0] req_addr [2];
    logic [7:0]  req_wdata [2];
    logic        req_rd [2];
    logic        req_wr [2];
    logic [7:0]  m0_rdata, m1_rdata;
    logic        m0_ready, m1_ready, m0_err, m1_err;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;
    logic        mem_read, mem_write, mem_ready;
    logic [1:0]  grant;
    logic        busy, timeout_err;
    logic [7:0]  rdata_o [2];
    logic        rdy_o [2];
    logic        err_o [2];

    assign rdata_o[0] = m0_rdata;
    assign rdata_o[1] = m1_rdata;
    assign rdy_o[0]   = m0_ready;
    assign rdy_o[1]   = m1_ready;
    assign err_o[0]   = m0_err;
    assign err_o[1]   = m1_err;

    mem_bus_arbiter #(.RR(1), .TIMEOUT(To)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_addr(req_addr[0]), .m0_wdata(req_wdata[0]), .m0_read(req_rd[0]),
        .m0_write(req_wr[0]), .m0_rdata(m0_rdata), .m0_ready(m0_ready), .m0_err(m0_err),
        .m1_addr(req_addr[1]), .m1_wdata(req_wdata[1]), .m1_read(req_rd[1]),
        .m1_write(req_wr[1]), .m1_rdata(m1_rdata), .m1_ready(m1_ready), .m1_err(m1_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
        .mem_write(mem_write), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .grant(grant), .busy(busy), .timeout_err(timeout_err)
    );

    // Fixed-priority instance, both masters requesting reads continuously
    logic [7:0]  f_m0_rdata, f_m1_rdata, f_mem_wdata;
    logic        f_m0_ready, f_m1_ready, f_m0_err, f_m1_err;
    logic [15:0] f_mem_addr;
    logic        f_mem_read, f_mem_write, f_busy, f_terr;
    logic        f_mem_ready;
    logic [1:0]  f_grant;

    mem_bus_arbiter #(.RR(0), .TIMEOUT(To)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .m0_addr(16'h0100), .m0_wdata(8'h00), .m0_read(1'b1), .m0_write(1'b0),
        .m0_rdata(f_m0_rdata), .m0_ready(f_m0_ready), .m0_err(f_m0_err),
        .m1_addr(16'h0200), .m1_wdata(8'h00), .m1_read(1'b1), .m1_write(1'b0),
        .m1_rdata(f_m1_rdata), .m1_ready(f_m1_ready), .m1_err(f_m1_err),
        .mem_addr(f_mem_addr), .mem_wdata(f_mem_wdata), .mem_read(f_mem_read),
        .mem_write(f_mem_write), .mem_rdata(8'h3C), .mem_ready(f_mem_ready),
        .grant(f_grant), .busy(f_busy), .timeout_err(f_terr)
    );

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;

    op_t oq0[$];
    op_t oq1[$];
    bit  act [2];
    op_t cur_op [2];
    int  gapc [2];

    // Model: at most one transaction, described by start cycle and strobe duration
    bit          tx_on;
    int          tx_own, tx_s, tx_d, tx_lat;
    bit          tx_wr, tx_to;
    logic [15:0] tx_addr;
    logic [7:0]  tx_wdata;
    int          next_ok;
    int          last_own;
    logic [7:0]  exp_rd [2];
    bit          rd_known [2];
    logic [7:0]  ref_mem [65536];
    logic [7:0]  dev_mem [65536];
    int          mcnt;

    logic [1:0]  gseq[$];
    bit          prev_busy;
    int          rd_cnt, wr_cnt, terr_cnt, fp_m0_cnt;
    logic [7:0]  last_rdata [2];
    logic        last_err [2];
    int          last_rdc, last_wrc;

    task automatic check(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
        n_chk++;
        if (act_v === exp_v) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act_v, exp_v, cyc);
    endtask

    task automatic push(input int m, input logic rd, input logic wr, input logic [15:0] a,
                        input logic [7:0] d, input int gap, input int lat);
        op_t o;
        o.rd = rd; o.wr = wr; o.addr = a; o.wdata = d; o.gap = gap; o.lat = lat;
        if (m == 0) oq0.push_back(o);
        else oq1.push_back(o);
    endtask

    task automatic step();
        int  ph;
        bit  e_rdy;
        bit  q0, q1;
        cyc++;
        if (tx_on && cyc == tx_s + tx_d + 1) begin
            tx_on   = 1'b0;
            next_ok = cyc + 1;
        end
        q0 = req_rd[0] | req_wr[0];
        q1 = req_rd[1] | req_wr[1];
        if (!tx_on && cyc >= next_ok && (q0 || q1)) begin
            tx_own   = (q0 && q1) ? ((last_own == 0) ? 1 : 0) : (q1 ? 1 : 0);
            last_own = tx_own;
            tx_on    = 1'b1;
            tx_wr    = req_wr[tx_own];
            tx_addr  = req_addr[tx_own];
            tx_wdata = req_wdata[tx_own];
            tx_lat   = cur_op[tx_own].lat;
            tx_to    = tx_lat > int'(To);
            tx_d     = tx_to ? int'(To) : tx_lat;
            tx_s     = cyc;
        end
        ph = 0;
        if (tx_on) ph = (cyc < tx_s + tx_d) ? 1 : 2;
        if (ph == 2) begin
            if (tx_to) begin
                exp_rd[tx_own] = 8'hFF; rd_known[tx_own] = 1'b1;
            end else if (tx_wr) begin
                ref_mem[tx_addr] = tx_wdata; rd_known[tx_own] = 1'b0;
            end else begin
                exp_rd[tx_own] = ref_mem[tx_addr]; rd_known[tx_own] = 1'b1;
            end
        end

        check("mem_read", 32'(mem_read), 32'(ph == 1 && !tx_wr));
        check("mem_write", 32'(mem_write), 32'(ph == 1 && tx_wr));
        check("grant", 32'(grant), (ph != 0) ? ((tx_own == 1) ? 32'd2 : 32'd1) : 32'd0);
        check("busy", 32'(busy), 32'(ph != 0));
        check("timeout_err", 32'(timeout_err), 32'(ph == 2 && tx_to));
        if (ph == 1) begin
            check("mem_addr", 32'(mem_addr), 32'(tx_addr));
            if (tx_wr) check("mem_wdata", 32'(mem_wdata), 32'(tx_wdata));
        end
        for (int m = 0; m < 2; m++) begin
            e_rdy = (ph == 2) && (tx_own == m);
            check($sformatf("m%0d_ready", m), 32'(rdy_o[m]), 32'(e_rdy));
            check($sformatf("m%0d_err", m), 32'(err_o[m]), 32'(e_rdy && tx_to));
            if (rd_known[m]) check($sformatf("m%0d_rdata", m), 32'(rdata_o[m]), 32'(exp_rd[m]));
        end

        check("fp_no_m1_grant", 32'(f_grant == 2'b10), 32'd0);
        check("fp_no_m1_ready", 32'(f_m1_ready), 32'd0);
        if (f_m0_ready) begin
            fp_m0_cnt++;
            check("fp_m0_rdata", 32'(f_m0_rdata), 32'h3C);
        end
        f_mem_ready = f_mem_read | f_mem_write;

        if (busy && !prev_busy) gseq.push_back(grant);
        prev_busy = busy;
        if (mem_read) rd_cnt++;
        if (mem_write) wr_cnt++;
        if (timeout_err) terr_cnt++;
        for (int m = 0; m < 2; m++) begin
            if (rdy_o[m]) begin
                last_rdata[m] = rdata_o[m];
                last_err[m]   = err_o[m];
                last_rdc = rd_cnt; last_wrc = wr_cnt;
                rd_cnt = 0; wr_cnt = 0;
            end
        end

        // Memory: completes after tx_lat strobe cycles; stray ready pulses while idle
        if (mem_read || mem_write) begin
            mcnt++;
            if (mcnt == tx_lat) begin
                mem_ready = 1'b1;
                if (mem_write) dev_mem[mem_addr] = mem_wdata;
                mem_rdata = mem_write ? 8'($urandom) : dev_mem[mem_addr];
            end else begin
                mem_ready = 1'b0;
                mem_rdata = 8'($urandom);
            end
        end else begin
            mcnt      = 0;
            mem_ready = ($urandom_range(3) == 0);
            mem_rdata = 8'($urandom);
        end

        for (int m = 0; m < 2; m++) begin
            int  qs;
            op_t o;
            if (act[m] && rdy_o[m]) begin
                act[m] = 1'b0; req_rd[m] = 1'b0; req_wr[m] = 1'b0;
            end
            qs = (m == 0) ? oq0.size() : oq1.size();
            if (!act[m] && qs > 0) begin
                o = (m == 0) ? oq0[0] : oq1[0];
                if (gapc[m] < o.gap) begin
                    gapc[m]++;
                end else begin
                    if (m == 0) o = oq0.pop_front();
                    else o = oq1.pop_front();
                    gapc[m] = 0; act[m] = 1'b1; cur_op[m] = o;
                    req_rd[m] = o.rd; req_wr[m] = o.wr;
                    req_addr[m] = o.addr; req_wdata[m] = o.wdata;
                end
            end
        end
    endtask

    task automatic run_until_idle(input int budget);
        int n = 0;
        while (!(oq0.size() == 0 && oq1.size() == 0 && !act[0] && !act[1] && !tx_on)
               && n < budget) begin
            @(negedge clk);
            step();
            n++;
        end
        check("idle_within_budget", 32'(n < budget), 32'd1);
    endtask

    task automatic zero_checks(input string tag);
        check({tag, "_mem_read"}, 32'(mem_read), 0);
        check({tag, "_mem_write"}, 32'(mem_write), 0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 0);
        check({tag, "_mem_wdata"}, 32'(mem_wdata), 0);
        check({tag, "_grant"}, 32'(grant), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_timeout_err"}, 32'(timeout_err), 0);
        check({tag, "_m0"}, {22'd0, m0_ready, m0_err, m0_rdata}, 0);
        check({tag, "_m1"}, {22'd0, m1_ready, m1_err, m1_rdata}, 0);
        check({tag, "_fp_grant"}, 32'(f_grant), 0);
    endtask

    task automatic model_reset();
        tx_on = 1'b0; last_own = 1; prev_busy = 1'b0;
        mcnt = 0; mem_ready = 1'b0; f_mem_ready = 1'b0;
        rd_cnt = 0; wr_cnt = 0;
        for (int m = 0; m < 2; m++) begin
            exp_rd[m] = 8'h00; rd_known[m] = 1'b1;
            act[m] = 1'b0; gapc[m] = 0; req_rd[m] = 1'b0; req_wr[m] = 1'b0;
        end
    endtask

    initial begin
        int n;
        logic [1:0] g;
        logic [1:0] exp_g [4];
        for (int i = 0; i < 65536; i++) begin
            logic [15:0] a;
            a = 16'(i);
            ref_mem[i] = a[7:0] ^ a[15:8];
            dev_mem[i] = a[7:0] ^ a[15:8];
        end
        ref_mem[16'h8000] = 8'h04;
        dev_mem[16'h8000] = 8'h04;
        for (int m = 0; m < 2; m++) begin
            req_addr[m] = 16'h0; req_wdata[m] = 8'h0;
        end
        mem_rdata = 8'h00;
        model_reset();

        repeat (3) @(negedge clk);
        zero_checks("reset");
        rst_n = 1'b1;
        next_ok = cyc + 1;

        // Round-robin with both masters requesting back to back
        gseq.delete();
        push(0, 1, 0, 16'h0100, 8'h00, 0, 2); push(0, 1, 0, 16'h0101, 8'h00, 0, 2);
        push(1, 1, 0, 16'h0200, 8'h00, 0, 2); push(1, 1, 0, 16'h0201, 8'h00, 0, 2);
        run_until_idle(200);
        exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
        check("rr_count", 32'(gseq.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            g = (i < gseq.size()) ? gseq[i] : 2'b11;
            check($sformatf("rr_grant%0d", i), 32'(g), 32'(exp_g[i]));
        end

        // Preloaded read
        push(0, 1, 0, 16'h8000, 8'h00, 0, 2);
        run_until_idle(100);
        check("rd8000_data", 32'(last_rdata[0]), 32'h04);
        check("rd8000_err", 32'(last_err[0]), 32'd0);
        check("rd8000_strobes", 32'(last_rdc), 32'd2);

        // Write from master 1, read back from master 0
        push(1, 0, 1, 16'h1234, 8'hA5, 0, 2);
        run_until_idle(100);
        check("wr1234_strobes", 32'(last_wrc), 32'd2);
        check("wr1234_mem", 32'(dev_mem[16'h1234]), 32'hA5);
        push(0, 1, 0, 16'h1234, 8'h00, 0, 2);
        run_until_idle(100);
        check("rd1234_data", 32'(last_rdata[0]), 32'hA5);

        // Watchdog abort, then a normal read of the same address
        terr_cnt = 0;
        push(0, 1, 0, 16'h0010, 8'h00, 0, 1000);
        run_until_idle(100);
        check("to_strobes", 32'(last_rdc), 32'd8);
        check("to_err", 32'(last_err[0]), 32'd1);
        check("to_rdata", 32'(last_rdata[0]), 32'hFF);
        check("to_pulses", 32'(terr_cnt), 32'd1);
        push(0, 1, 0, 16'h0010, 8'h00, 0, 2);
        run_until_idle(100);
        check("after_to_data", 32'(last_rdata[0]), 32'h10);
        check("after_to_err", 32'(last_err[0]), 32'd0);

        // Ready on the last allowed cycle completes; one later aborts
        push(0, 1, 0, 16'h0203, 8'h00, 0, 8);
        run_until_idle(100);
        check("lat8_err", 32'(last_err[0]), 32'd0);
        check("lat8_data", 32'(last_rdata[0]), 32'h01);
        push(0, 1, 0, 16'h0203, 8'h00, 0, 9);
        run_until_idle(100);
        check("lat9_err", 32'(last_err[0]), 32'd1);

        // Read and write together: write wins
        push(0, 1, 1, 16'h0020, 8'h5A, 0, 2);
        run_until_idle(100);
        check("rw_rd_strobes", 32'(last_rdc), 32'd0);
        check("rw_wr_strobes", 32'(last_wrc), 32'd2);
        check("rw_mem", 32'(dev_mem[16'h0020]), 32'h5A);

        // Reset in the middle of an access
        push(0, 1, 0, 16'h0040, 8'h00, 0, 1000);
        n = 0;
        while (!(tx_on && cyc == tx_s + 3) && n < 50) begin
            @(negedge clk);
            step();
            n++;
        end
        check("reach_access", 32'(n < 50), 32'd1);
        #2 rst_n = 1'b0;
        #1 zero_checks("midreset");
        model_reset();
        cur_op[1].rd = 1'b1; cur_op[1].wr = 1'b0; cur_op[1].addr = 16'h8000;
        cur_op[1].wdata = 8'h00; cur_op[1].gap = 0; cur_op[1].lat = 2;
        act[1] = 1'b1; req_rd[1] = 1'b1; req_addr[1] = 16'h8000;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        next_ok = cyc + 1;
        gseq.delete();
        run_until_idle(100);
        check("post_reset_grants", 32'(gseq.size()), 32'd1);
        g = (gseq.size() > 0) ? gseq[0] : 2'b11;
        check("post_reset_owner", 32'(g), 32'd2);
        check("post_reset_data", 32'(last_rdata[1]), 32'h04);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            int k, t, lat;
            logic [15:0] a;
            k = $urandom_range(3);
            t = $urandom_range(9);
            lat = (t < 7) ? int'($urandom_range(1, 4)) : ((t == 7) ? 8 : ((t == 8) ? 9 : 30));
            a = ($urandom_range(1) == 0) ? 16'($urandom_range(15)) : 16'($urandom);
            push(i % 2, (k != 1), (k == 1 || k == 2), a, 8'($urandom),
                 $urandom_range(0, 3), lat);
        end
        run_until_idle(20000);
        check("fp_m0_served", 32'(fp_m0_cnt > 0), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
